// File: rtl/aeolus_control_unit_pkg.sv
// Shared encodings for the Aeolus 4-bit CPU: opcodes, sequencer states,
// ALU operation select and accumulator source select.
package aeolus_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_LDR  = 4'hC;
    localparam logic [3:0] OP_STR  = 4'hD;
    localparam logic [3:0] OP_WAIT = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    localparam logic [1:0] ACC_SEL_ALU = 2'd0;
    localparam logic [1:0] ACC_SEL_IMM = 2'd1;
    localparam logic [1:0] ACC_SEL_SW  = 2'd2;
    localparam logic [1:0] ACC_SEL_REG = 2'd3;

    // Maps an ALU-class opcode to its ALU operation; anything else passes.
    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        logic [2:0] r;
        r = ALU_PASS;
        case (op)
            OP_ADD:  r = ALU_ADD;
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            OP_OR:   r = ALU_OR;
            OP_XOR:  r = ALU_XOR;
            default: r = ALU_PASS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aeolus_control_unit_if.sv
// Bus between the Aeolus sequencer and its surroundings (ROM, datapath,
// switch synchronizer).
//
// Switch handshake: the synchronizer raises in_valid_i and holds it until it
// sees in_ack_o high on a rising edge. in_ack_o is a one-cycle pulse issued
// only while an IN/WAIT instruction is executing; in_valid_i is ignored at
// every other time, and a nibble is consumed exactly when both are high.
interface aeolus_control_unit_if #(
    parameter int PC_W = 4
);
    logic [7:0]      instr_i;
    logic            zero_i;
    logic            carry_i;
    logic            in_valid_i;
    logic            in_ack_o;
    logic [PC_W-1:0] pc_o;
    logic [3:0]      imm_o;
    logic [2:0]      alu_op_o;
    logic [1:0]      acc_sel_o;
    logic            acc_we_o;
    logic            flag_we_o;
    logic            reg_we_o;
    logic            out_we_o;
    logic            halted_o;
    logic [1:0]      state_o;

    // Sequencer side.
    modport master (
        input  instr_i, zero_i, carry_i, in_valid_i,
        output in_ack_o, pc_o, imm_o, alu_op_o, acc_sel_o, acc_we_o,
               flag_we_o, reg_we_o, out_we_o, halted_o, state_o
    );

    // ROM / datapath / synchronizer side.
    modport slave (
        output instr_i, zero_i, carry_i, in_valid_i,
        input  in_ack_o, pc_o, imm_o, alu_op_o, acc_sel_o, acc_we_o,
               flag_we_o, reg_we_o, out_we_o, halted_o, state_o
    );

endinterface

// File: rtl/aeolus_pc.sv
// Program counter: load has priority over increment, increment wraps
// naturally at 2^PC_W.
module aeolus_pc #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next PC: jump target, sequential successor, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end else if (inc_en) begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // PC register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/aeolus_control_unit.sv
// Aeolus multi-cycle sequencer: FETCH -> DECODE -> EXECUTE per instruction,
// with IN/WAIT stalling in EXECUTE until a switch nibble is offered and HLT
// parking in HALT until reset. Strobes are pure decode of state + IR.
module aeolus_control_unit
    import aeolus_control_unit_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic                   boardCLK,
    input  logic                   reset,
    aeolus_control_unit_if.master  bus
);
    state_e          state_q, state_d;
    logic [7:0]      ir_q, ir_d;
    logic [3:0]      opcode;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] jump_target;
    logic            pc_load;
    logic            pc_inc;

    logic            in_ack;
    logic [2:0]      alu_op;
    logic [1:0]      acc_sel;
    logic            acc_we;
    logic            flag_we;
    logic            reg_we;
    logic            out_we;

    assign opcode      = ir_q[7:4];
    assign jump_target = PC_W'(ir_q[3:0]);

    aeolus_pc #(.PC_W(PC_W)) u_pc (
        .clk      (boardCLK),
        .rst_n    (reset),
        .load_en  (pc_load),
        .load_val (jump_target),
        .inc_en   (pc_inc),
        .pc_o     (pc)
    );

    // Next-state, IR capture, PC control and per-opcode strobe decode.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        in_ack  = 1'b0;
        alu_op  = ALU_PASS;
        acc_sel = ACC_SEL_ALU;
        acc_we  = 1'b0;
        flag_we = 1'b0;
        reg_we  = 1'b0;
        out_we  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                // ROM is reading pc; its data arrives during DECODE.
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = bus.instr_i;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                pc_inc  = 1'b1;
                case (opcode)
                    OP_NOP: ;
                    OP_LDI: begin
                        acc_sel = ACC_SEL_IMM;
                        acc_we  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        alu_op  = alu_op_of(opcode);
                        acc_sel = ACC_SEL_ALU;
                        acc_we  = 1'b1;
                        flag_we = 1'b1;
                    end
                    OP_IN, OP_WAIT: begin
                        if (bus.in_valid_i) begin
                            in_ack  = 1'b1;
                            acc_sel = ACC_SEL_SW;
                            acc_we  = 1'b1;
                        end else begin
                            // Stall: hold state and PC, all strobes low.
                            state_d = ST_EXECUTE;
                            pc_inc  = 1'b0;
                        end
                    end
                    OP_OUT: out_we = 1'b1;
                    OP_JMP: pc_load = 1'b1;
                    OP_JZ:  pc_load = bus.zero_i;
                    OP_JC:  pc_load = bus.carry_i;
                    OP_LDR: begin
                        acc_sel = ACC_SEL_REG;
                        acc_we  = 1'b1;
                    end
                    OP_STR: reg_we = 1'b1;
                    OP_HLT: begin
                        state_d = ST_HALT;
                        pc_inc  = 1'b0;
                    end
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State and instruction register, asynchronously cleared.
    always_ff @(posedge boardCLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.in_ack_o  = in_ack;
    assign bus.pc_o      = pc;
    assign bus.imm_o     = ir_q[3:0];
    assign bus.alu_op_o  = alu_op;
    assign bus.acc_sel_o = acc_sel;
    assign bus.acc_we_o  = acc_we;
    assign bus.flag_we_o = flag_we;
    assign bus.reg_we_o  = reg_we;
    assign bus.out_we_o  = out_we;
    assign bus.halted_o  = (state_q == ST_HALT);
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_aeolus_control_unit.sv
// Bench for aeolus_control_unit: a synchronous ROM model, an instruction-level
// reference model compared every cycle, an acknowledge scoreboard and
// directed programs with hand-computed expectations.
module tb_aeolus_control_unit;
  localparam int PC_W = 4;

  // ---------------- clock / reset ----------------
  logic boardCLK = 1'b0;
  logic reset    = 1'b0;
  always #5 boardCLK = ~boardCLK;

  aeolus_control_unit_if #(.PC_W(PC_W)) bus();

  aeolus_control_unit #(.PC_W(PC_W)) dut (
    .boardCLK (boardCLK),
    .reset    (reset),
    .bus      (bus)
  );

  // Synchronous program ROM: data valid one cycle after the address.
  logic [7:0] rom [16];
  always @(posedge boardCLK) bus.instr_i <= rom[bus.pc_o];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  int m_pc = 0;
  int m_phase = 0;
  bit m_halted = 1'b0;

  always @(negedge boardCLK) begin : model_cmp
    logic [7:0] ins;
    int op, imm;
    int e_st, e_ack, e_alu, e_sel, e_awe, e_fwe, e_rwe, e_owe, e_halt, e_pc, e_imm;
    bit do_imm;
    int nxt_pc, nxt_phase;
    bit nxt_halt;
    ins = rom[m_pc];
    op = int'(ins[7:4]);
    imm = int'(ins[3:0]);
    e_ack = 0; e_alu = 0; e_sel = 0; e_awe = 0; e_fwe = 0; e_rwe = 0; e_owe = 0;
    e_halt = 0; e_imm = 0; do_imm = 1'b0;
    e_pc = m_pc; e_st = m_phase;
    nxt_pc = m_pc; nxt_phase = (m_phase + 1) % 3; nxt_halt = m_halted;
    if (!reset) begin
      e_st = 0; e_pc = 0; do_imm = 1'b1; e_imm = 0;
      nxt_pc = 0; nxt_phase = 0; nxt_halt = 1'b0;
    end else if (m_halted) begin
      e_st = 3; e_halt = 1; nxt_phase = m_phase;
    end else if (m_phase == 2) begin
      do_imm = 1'b1; e_imm = imm;
      nxt_phase = 0; nxt_pc = (m_pc + 1) % 16;
      if (op >= 2 && op <= 6) begin
        e_alu = op - 1; e_awe = 1; e_fwe = 1;
      end else if (op == 1) begin
        e_sel = 1; e_awe = 1;
      end else if (op == 12) begin
        e_sel = 3; e_awe = 1;
      end else if (op == 13) begin
        e_rwe = 1;
      end else if (op == 8) begin
        e_owe = 1;
      end else if (op == 7 || op == 14) begin
        if (bus.in_valid_i) begin
          e_ack = 1; e_sel = 2; e_awe = 1;
        end else begin
          nxt_phase = 2; nxt_pc = m_pc;
        end
      end else if (op == 9) begin
        nxt_pc = imm;
      end else if (op == 10) begin
        if (bus.zero_i) nxt_pc = imm;
      end else if (op == 11) begin
        if (bus.carry_i) nxt_pc = imm;
      end else if (op == 15) begin
        nxt_halt = 1'b1; nxt_pc = m_pc;
      end
    end
    check("m_state",   32'(bus.state_o),   32'(e_st));
    check("m_pc",      32'(bus.pc_o),      32'(e_pc));
    check("m_in_ack",  32'(bus.in_ack_o),  32'(e_ack));
    check("m_alu_op",  32'(bus.alu_op_o),  32'(e_alu));
    check("m_acc_sel", 32'(bus.acc_sel_o), 32'(e_sel));
    check("m_acc_we",  32'(bus.acc_we_o),  32'(e_awe));
    check("m_flag_we", 32'(bus.flag_we_o), 32'(e_fwe));
    check("m_reg_we",  32'(bus.reg_we_o),  32'(e_rwe));
    check("m_out_we",  32'(bus.out_we_o),  32'(e_owe));
    check("m_halted",  32'(bus.halted_o),  32'(e_halt));
    if (do_imm) check("m_imm", 32'(bus.imm_o), 32'(e_imm));
    m_pc = nxt_pc; m_phase = nxt_phase; m_halted = nxt_halt;
  end

  // ---------------- acknowledge scoreboard ----------------
  always @(negedge boardCLK) begin
    if (bus.in_ack_o === 1'b1) begin
      if (exp_q.size() == 0) check("ack_unexpected", 32'(bus.in_ack_o), 32'd0);
      else check("ack_pc", 32'(bus.pc_o), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge boardCLK);
    cyc++;
  endtask

  task automatic go(input int k);
    while (cyc < k) step();
  endtask

  task automatic begin_test();
    @(posedge boardCLK); #1;
    reset = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.zero_i = 1'b0;
    bus.carry_i = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge boardCLK);
    #1 reset = 1'b1;
    cyc = 0;
  endtask

  task automatic drive_after_edge(input logic v);
    @(posedge boardCLK); #1;
    bus.in_valid_i = v;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.in_valid_i = 1'b0;
    bus.zero_i = 1'b0;
    bus.carry_i = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // T1: LDI 5 then NOPs through the wrap of the 16-entry ROM.
    begin_test();
    rom[0] = 8'h15;
    @(negedge boardCLK);
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_pc", 32'(bus.pc_o), 32'd0);
    check("rst_acc_we", 32'(bus.acc_we_o), 32'd0);
    release_reset();
    go(1);
    check("t1_c1_state", 32'(bus.state_o), 32'd0);
    go(3);
    check("t1_ldi_acc_we", 32'(bus.acc_we_o), 32'd1);
    check("t1_ldi_acc_sel", 32'(bus.acc_sel_o), 32'd1);
    check("t1_ldi_imm", 32'(bus.imm_o), 32'd5);
    go(4);
    check("t1_pc_after", 32'(bus.pc_o), 32'd1);
    go(48);
    check("t1_last_pc", 32'(bus.pc_o), 32'd15);
    go(49);
    check("t1_wrap_pc", 32'(bus.pc_o), 32'd0);
    check("t1_wrap_state", 32'(bus.state_o), 32'd0);

    // T2: LDI 3, ADD 15, JZ 7 (not taken), JC 0 (taken).
    begin_test();
    rom[0] = 8'h13; rom[1] = 8'h2F; rom[2] = 8'hA7; rom[3] = 8'hB0;
    release_reset();
    go(6);
    check("t2_add_alu_op", 32'(bus.alu_op_o), 32'd1);
    check("t2_add_flag_we", 32'(bus.flag_we_o), 32'd1);
    check("t2_add_acc_sel", 32'(bus.acc_sel_o), 32'd0);
    @(posedge boardCLK); #1 bus.carry_i = 1'b1;
    go(10);
    check("t2_jz_not_taken", 32'(bus.pc_o), 32'd3);
    go(13);
    check("t2_jc_taken", 32'(bus.pc_o), 32'd0);

    // T3: mixed opcodes, IN with data ready, WAIT stalling 4 cycles, JMP self.
    begin_test();
    rom[0] = 8'h1A; rom[1] = 8'h31; rom[2] = 8'h42; rom[3] = 8'h53;
    rom[4] = 8'h64; rom[5] = 8'hD2; rom[6] = 8'hC2; rom[7] = 8'h85;
    rom[8] = 8'h70; rom[9] = 8'hE0; rom[10] = 8'h9A;
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd9);
    bus.in_valid_i = 1'b1;
    release_reset();
    go(6);
    check("t3_sub_alu_op", 32'(bus.alu_op_o), 32'd2);
    go(18);
    check("t3_str_reg_we", 32'(bus.reg_we_o), 32'd1);
    check("t3_str_imm", 32'(bus.imm_o), 32'd2);
    go(21);
    check("t3_ldr_acc_sel", 32'(bus.acc_sel_o), 32'd3);
    go(24);
    check("t3_out_we", 32'(bus.out_we_o), 32'd1);
    go(27);
    check("t3_in_ack", 32'(bus.in_ack_o), 32'd1);
    check("t3_in_acc_sel", 32'(bus.acc_sel_o), 32'd2);
    drive_after_edge(1'b0);
    for (int c = 30; c <= 33; c++) begin
      go(c);
      check("t3_stall_state", 32'(bus.state_o), 32'd2);
      check("t3_stall_ack", 32'(bus.in_ack_o), 32'd0);
      check("t3_stall_acc_we", 32'(bus.acc_we_o), 32'd0);
    end
    drive_after_edge(1'b1);
    go(34);
    check("t3_wait_ack", 32'(bus.in_ack_o), 32'd1);
    check("t3_wait_acc_we", 32'(bus.acc_we_o), 32'd1);
    check("t3_wait_acc_sel", 32'(bus.acc_sel_o), 32'd2);
    drive_after_edge(1'b0);
    go(35);
    check("t3_after_wait_pc", 32'(bus.pc_o), 32'd10);
    go(38);
    check("t3_jmp_self_pc", 32'(bus.pc_o), 32'd10);
    check("t3_jmp_self_state", 32'(bus.state_o), 32'd0);
    go(41);
    check("t3_jmp_self_pc2", 32'(bus.pc_o), 32'd10);
    check("t3_acks_consumed", 32'(exp_q.size()), 32'd0);

    // T4: reset during a WAIT stall, with in_valid rising in the same cycle.
    begin_test();
    rom[0] = 8'hE0;
    release_reset();
    go(4);
    check("t4_stall_state", 32'(bus.state_o), 32'd2);
    @(posedge boardCLK); #1;
    reset = 1'b0;
    bus.in_valid_i = 1'b1;
    #1;
    check("t4_rst_state_now", 32'(bus.state_o), 32'd0);
    check("t4_rst_ack_now", 32'(bus.in_ack_o), 32'd0);
    repeat (3) step();
    check("t4_rst_pc", 32'(bus.pc_o), 32'd0);
    check("t4_rst_ack", 32'(bus.in_ack_o), 32'd0);

    // T5: LDI 1 then HLT; in_valid pulses must be ignored, PC frozen.
    begin_test();
    rom[0] = 8'h11; rom[1] = 8'hF0;
    release_reset();
    go(6);
    check("t5_hlt_exec_state", 32'(bus.state_o), 32'd2);
    go(7);
    check("t5_halted", 32'(bus.halted_o), 32'd1);
    check("t5_halt_state", 32'(bus.state_o), 32'd3);
    for (int i = 0; i < 8; i++) begin
      drive_after_edge(i[0] == 1'b0);
      step();
    end
    check("t5_halted_late", 32'(bus.halted_o), 32'd1);
    check("t5_pc_frozen", 32'(bus.pc_o), 32'd1);
    check("t5_no_ack", 32'(bus.in_ack_o), 32'd0);
    check("t5_no_acks_queued", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aeolus_control_unit.md
# aeolus_control_unit

Multi-cycle instruction sequencer for the Aeolus 4-bit CPU. Owns the program counter, fetches 8-bit instructions from the synchronous program ROM, decodes the 4-bit opcode and drives one-cycle control strobes into the accumulator/ALU/register-file datapath inside `AeolusCPUTop`. Also handshakes with the switch-input synchronizer for blocking input and latches a halt state.

## Interface
- `PC_W`, default 4: program counter width; ROM depth is 2^PC_W.
- `boardCLK`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_i`  in  8  ROM data: `[7:4]` opcode, `[3:0]` operand. Valid one cycle after `pc_o` changes.
- `zero_i`  in  1  registered zero flag from the datapath.
- `carry_i`  in  1  registered carry flag from the datapath.
- `in_valid_i`  in  1  switch nibble ready.
- `in_ack_o`  out  1  one-cycle acknowledge consuming the switch nibble.
- `pc_o`  out  PC_W  ROM address.
- `imm_o`  out  4  operand field of the latched instruction.
- `alu_op_o`  out  3  0 pass, 1 add, 2 sub, 3 and, 4 or, 5 xor.
- `acc_sel_o`  out  2  accumulator source: 0 ALU, 1 imm, 2 switches, 3 reg.
- `acc_we_o`  out  1  accumulator write strobe.
- `flag_we_o`  out  1  zero/carry update strobe; asserted with ALU ops only.
- `reg_we_o`  out  1  register-file write strobe; address is `imm_o[1:0]`.
- `out_we_o`  out  1  `cpuOut` register write strobe.
- `halted_o`  out  1  high in HALT.
- `state_o`  out  2  current state, for debug.

## Operation
- Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 IN, 8 OUT, 9 JMP, A JZ, B JC, C LDR, D STR, E WAIT, F HLT.
- States: FETCH(0), DECODE(1), EXECUTE(2), HALT(3).
- FETCH: `pc_o` is stable and the ROM is reading. Go to DECODE.
- DECODE: latch `instr_i` into IR and drive `imm_o` from IR. Go to EXECUTE.
- EXECUTE: assert this opcode's strobes for exactly one cycle.
  - ADD..XOR: `acc_sel_o`=0, `acc_we_o`=1, `flag_we_o`=1.
  - LDI: `acc_sel_o`=1, `acc_we_o`=1.
  - LDR: `acc_sel_o`=3, `acc_we_o`=1.
  - STR: `reg_we_o`=1.
  - OUT: `out_we_o`=1.
  - IN and WAIT: if `in_valid_i`=0, stay in EXECUTE with all strobes low. When `in_valid_i`=1, assert `acc_sel_o`=2, `acc_we_o`=1 and `in_ack_o`=1 in the same cycle, then proceed.
  - IN and WAIT decode identically; WAIT exists for assembler readability.
- PC update at the end of EXECUTE:
  - JMP: PC←imm.
  - JZ: PC←imm if `zero_i`, else PC+1.
  - JC: PC←imm if `carry_i`, else PC+1.
  - All other opcodes: PC+1, wrapping from 2^PC_W−1 to 0.
  - Then go to FETCH.
- HLT: go from EXECUTE to HALT; PC is not incremented. HALT is held until reset; all strobes stay low and `halted_o`=1.
- Flags are sampled in EXECUTE. Because strobes from the previous instruction take effect before the current FETCH, the flags reflect the last ALU instruction.
- Reset (async, any state): state FETCH, PC 0, IR 0.
  - All strobes, `in_ack_o` and `halted_o` are 0; `alu_op_o` is 0; `acc_sel_o` is 0.
  - A reset asserted mid-stall in WAIT drops `in_ack_o` immediately, and no acknowledge is issued.
- Strobes are decoded combinationally from state+IR. The registered PC and state are the only sequential outputs.

## Timing
- Non-stalling instruction: 3 cycles. IN/WAIT: 3 + stall cycles.
- First FETCH occurs in the first rising edge after `reset` deasserts. `pc_o`=0 during that cycle.
- `in_valid_i` is sampled only in EXECUTE of IN/WAIT. A pulse arriving in any other state is ignored; the synchronizer must hold it until `in_ack_o`.
- `in_valid_i` and a taken reset in the same cycle: reset wins, and no ack is issued.
- Jump to the current address (e.g. JMP to itself) loops with period 3 cycles.

## Structure
- Shared include `src/AeolusDefs.vh` holds:
  - opcode localparams
  - state encoding
  - `alu_op` encoding
  - `acc_sel` encoding
- The datapath and assembler use the same include.
- One sub-module: `aeolus_pc` (PC register with load, increment, wrap and async reset). The FSM and decode stay in `aeolus_control_unit`.

## Test plan
- Reset release with ROM[0]=0x15 (LDI 5) → cycle 3 shows `acc_we_o`=1, `acc_sel_o`=1, `imm_o`=5; `pc_o` becomes 1 at cycle 3 end.
- ROM 0x13, 0x2F (LDI 3, ADD 15) → EXECUTE of ADD asserts `alu_op_o`=1 and `flag_we_o`=1. Datapath then sets `carry_i`=1; a following JC 0x0 loads PC=0.
- ROM[15]=0x00 → after its EXECUTE, `pc_o` wraps to 0.
- WAIT with `in_valid_i` low for 4 cycles then high → 4 stall cycles with strobes low, then a single cycle with `in_ack_o`=`acc_we_o`=1 and `acc_sel_o`=2.
- Assert `reset` low during the WAIT stall → `state_o`=0 and `pc_o`=0 immediately, with no ack ever observed.
- ROM 0xF0 → `halted_o`=1 and `state_o`=3 indefinitely. `in_valid_i` pulses produce no `in_ack_o`, and `pc_o` is frozen.
